// File: rtl/dev_arbiter_pkg.sv
// Shared definitions for the two-master device register arbiter.
// Holds the FSM state encoding, the default device window base and the slot
// stride. It also holds the register offset that is decoded but has no backing
// register, and the width of the CP0 hardware interrupt vector.
package dev_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StAccess = 2'd1,
    StAck    = 2'd2
  } dev_arb_state_e;

  localparam logic [31:0] DefaultBase = 32'h0000_7F00;
  localparam int unsigned SlotStride  = 16;
  localparam logic [3:0]  OffsetNoReg = 4'hC;
  localparam int unsigned HwIntW      = 6;

  // Register accesses are word-only; byte/halfword addresses are rejected.
  function automatic logic word_aligned(logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/dev_arb_rr.sv
// Two-requester round-robin picker.
// Ports:
//   req_i   requests from master 0 (bit 0) and master 1 (bit 1)
//   last_i  master granted most recently (0 or 1)
//   en_i    grant qualifier; no grant is issued while low
//   gnt_o   one-hot grant, zero when nothing is requested or en_i is low
module dev_arb_rr (
  input  logic [1:0] req_i,
  input  logic       last_i,
  input  logic       en_i,
  output logic [1:0] gnt_o
);

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        // Contention: favour whoever did not win last time.
        2'b11:   gnt_o = last_i ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/dev_arbiter.sv
// Arbitrates the CPU data port (m0) and the DMA/debug master (m1) onto the
// shared register port of up to NDEV memory-mapped devices, one access at a
// time (IDLE -> ACCESS -> ACK). It also registers device IRQs into HWInt.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   mN_req/we/addr/wdata  master request, held stable until mN_ack
//   mN_ack/err/rdata      one-cycle completion, error flag and read data
//   dev_add/wdata/we      register offset, write data, one-hot write enable
//   dev_rdata             combinational read data of every slot
//   dev_irq, hwint        device interrupt lines, registered CP0 vector
module dev_arbiter
  import dev_arbiter_pkg::*;
#(
  parameter int unsigned NDEV = 2,
  parameter logic [31:0] BASE = DefaultBase
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 m0_req,
  input  logic                 m0_we,
  input  logic [31:0]          m0_addr,
  input  logic [31:0]          m0_wdata,
  output logic                 m0_ack,
  output logic                 m0_err,
  output logic [31:0]          m0_rdata,
  input  logic                 m1_req,
  input  logic                 m1_we,
  input  logic [31:0]          m1_addr,
  input  logic [31:0]          m1_wdata,
  output logic                 m1_ack,
  output logic                 m1_err,
  output logic [31:0]          m1_rdata,
  output logic [3:0]           dev_add,
  output logic [31:0]          dev_wdata,
  output logic [NDEV-1:0]      dev_we,
  input  logic [32*NDEV-1:0]   dev_rdata,
  input  logic [NDEV-1:0]      dev_irq,
  output logic [HwIntW-1:0]    hwint
);

  localparam int unsigned SlotW = (NDEV > 1) ? $clog2(NDEV) : 1;
  localparam logic [31:0] Span  = 32'(SlotStride * NDEV);

  dev_arb_state_e    state_q;
  logic              ptr_q;
  logic              win_q;
  logic              we_q;
  logic              hit_q;
  logic [SlotW-1:0]  slot_q;
  logic [3:0]        dev_add_q;
  logic [31:0]       dev_wdata_q;
  logic [NDEV-1:0]   dev_we_q;
  logic [31:0]       rd_q;
  logic [1:0]        ack_q;
  logic              err_q;
  logic [HwIntW-1:0] hwint_q;
  logic [HwIntW-1:0] hwint_d;

  logic [1:0]        gnt;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [31:0]       sel_off;
  logic              sel_hit;
  logic [SlotW-1:0]  sel_slot;
  logic [NDEV-1:0]   sel_we_oh;
  logic [31:0]       rd_sel;

  dev_arb_rr u_rr (
    .req_i  ({m1_req, m0_req}),
    .last_i (ptr_q),
    .en_i   (state_q == StIdle),
    .gnt_o  (gnt)
  );

  // Winner's request and its address decode.
  always_comb begin
    sel_we    = gnt[1] ? m1_we    : m0_we;
    sel_addr  = gnt[1] ? m1_addr  : m0_addr;
    sel_wdata = gnt[1] ? m1_wdata : m0_wdata;
    sel_off   = sel_addr - BASE;
    sel_hit   = (sel_addr >= BASE) && (sel_off < Span) && word_aligned(sel_addr);
    sel_slot  = sel_off[4 +: SlotW];
    sel_we_oh = '0;
    if (sel_we && sel_hit && (sel_addr[3:0] != OffsetNoReg)) begin
      for (int i = 0; i < NDEV; i++) begin
        if (sel_slot == SlotW'(i)) sel_we_oh[i] = 1'b1;
      end
    end
  end

  // Read mux over the latched slot.
  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NDEV; i++) begin
      if (slot_q == SlotW'(i)) rd_sel = dev_rdata[32*i +: 32];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b1;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      hit_q       <= 1'b0;
      slot_q      <= '0;
      dev_add_q   <= '0;
      dev_wdata_q <= '0;
      dev_we_q    <= '0;
      rd_q        <= '0;
      ack_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt != 2'b00) begin
            ptr_q       <= gnt[1];
            win_q       <= gnt[1];
            we_q        <= sel_we;
            hit_q       <= sel_hit;
            slot_q      <= sel_slot;
            dev_add_q   <= sel_addr[3:0];
            dev_wdata_q <= sel_wdata;
            // Registered so the strobe lives exactly in the ACCESS cycle.
            dev_we_q    <= sel_we_oh;
            state_q     <= StAccess;
          end
        end
        StAccess: begin
          dev_we_q <= '0;
          if (hit_q && !we_q && (dev_add_q != OffsetNoReg)) begin
            rd_q <= rd_sel;
          end else begin
            rd_q <= '0;
          end
          ack_q        <= '0;
          ack_q[win_q] <= 1'b1;
          err_q        <= ~hit_q;
          state_q      <= StAck;
        end
        StAck: begin
          ack_q   <= '0;
          err_q   <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    hwint_d             = '0;
    hwint_d[NDEV-1:0]   = dev_irq;
  end

  always_ff @(posedge clk) begin
    if (reset) hwint_q <= '0;
    else       hwint_q <= hwint_d;
  end

  // Reset seen during ACCESS must kill the write in that same cycle.
  assign dev_we    = dev_we_q & {NDEV{~reset}};
  assign dev_add   = dev_add_q;
  assign dev_wdata = dev_wdata_q;
  assign hwint     = hwint_q;

  assign m0_ack   = ack_q[0];
  assign m0_err   = ack_q[0] & err_q;
  assign m0_rdata = ack_q[0] ? rd_q : 32'h0;
  assign m1_ack   = ack_q[1];
  assign m1_err   = ack_q[1] & err_q;
  assign m1_rdata = ack_q[1] ? rd_q : 32'h0;

endmodule

// File: tb/tb_dev_arbiter.sv
module tb_dev_arbiter;
  localparam int unsigned NDEV = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic [3:0] dev_add;
  logic [31:0] dev_wdata;
  logic [NDEV-1:0] dev_we;
  logic [32*NDEV-1:0] dev_rdata;
  logic [NDEV-1:0] dev_irq = '0;
  logic [5:0] hwint;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dev_arbiter #(.NDEV(NDEV), .BASE(32'h0000_7F00)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .dev_add(dev_add), .dev_wdata(dev_wdata), .dev_we(dev_we),
    .dev_rdata(dev_rdata), .dev_irq(dev_irq), .hwint(hwint)
  );

  // Simple device model: four words per slot; offset C reads as junk.
  logic [31:0] regs [NDEV][4] = '{default: '0};

  always @(posedge clk) begin
    for (int i = 0; i < NDEV; i++) begin
      if (dev_we[i]) regs[i][dev_add[3:2]] <= dev_wdata;
    end
  end

  always_comb begin
    dev_rdata = '0;
    for (int i = 0; i < NDEV; i++) begin
      dev_rdata[32*i +: 32] = (dev_add == 4'hC) ? 32'hDEAD_BEEF : regs[i][dev_add[3:2]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int m, input logic req, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  // One master alone; reports ack latency and what was seen on the way.
  task automatic run_access(input int m, input logic we, input logic [31:0] addr,
                            input logic [31:0] wdata, output int lat, output logic err,
                            output logic [31:0] rdata, output logic [NDEV-1:0] we_seen,
                            output logic [3:0] add_acc, output logic other_ack);
    logic a, oa;
    drive(m, 1'b1, we, addr, wdata);
    lat = -1; err = 0; rdata = 0; we_seen = '0; add_acc = 0; other_ack = 0;
    for (int k = 1; k <= 10 && lat < 0; k++) begin
      step();
      we_seen |= dev_we;
      if (k == 1) add_acc = dev_add;
      a  = (m == 0) ? m0_ack : m1_ack;
      oa = (m == 0) ? m1_ack : m0_ack;
      if (oa) other_ack = 1'b1;
      if (a) begin
        lat   = k;
        err   = (m == 0) ? m0_err : m1_err;
        rdata = (m == 0) ? m0_rdata : m1_rdata;
      end
    end
    drive(m, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  // Both masters raise requests in the same cycle.
  task automatic contend(input logic we, input logic [31:0] a0_addr, input logic [31:0] d0,
                         input logic [31:0] a1_addr, input logic [31:0] d1,
                         output int t0, output int t1, output logic [31:0] r0,
                         output logic [31:0] r1, output logic multi_we);
    drive(0, 1'b1, we, a0_addr, d0);
    drive(1, 1'b1, we, a1_addr, d1);
    t0 = -1; t1 = -1; r0 = 0; r1 = 0; multi_we = 0;
    for (int k = 1; k <= 12 && (t0 < 0 || t1 < 0); k++) begin
      step();
      if ($countones(dev_we) > 1) multi_we = 1'b1;
      if (m0_ack && t0 < 0) begin
        t0 = k; r0 = m0_rdata; drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
      end
      if (m1_ack && t1 < 0) begin
        t1 = k; r1 = m1_rdata; drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
      end
    end
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, t0, t1;
    logic err, oack, mwe;
    logic [31:0] rd, r0, r1;
    logic [NDEV-1:0] wes;
    logic [3:0] add;

    // Reset state
    reset = 1'b1;
    repeat (3) step();
    check("rst_state", 32'(dut.state_q), 32'd0);
    check("rst_ptr", 32'(dut.ptr_q), 32'd1);
    check("rst_acks", {28'h0, m0_ack, m0_err, m1_ack, m1_err}, 32'h0);
    check("rst_dev_we", 32'(dev_we), 32'h0);
    check("rst_dev_add", 32'(dev_add), 32'h0);
    check("rst_dev_wdata", dev_wdata, 32'h0);
    check("rst_hwint", 32'(hwint), 32'h0);
    reset = 1'b0;
    step();

    // m0 write 9 to 0x7F00, cycle by cycle
    drive(0, 1'b1, 1'b1, 32'h0000_7F00, 32'h0000_0009);
    check("wr_t0_dev_we", 32'(dev_we), 32'h0);
    step();
    check("wr_t1_dev_we", 32'(dev_we), 32'h1);
    check("wr_t1_dev_add", 32'(dev_add), 32'h0);
    check("wr_t1_dev_wdata", dev_wdata, 32'h9);
    check("wr_t1_ack", 32'(m0_ack), 32'h0);
    step();
    check("wr_t2_dev_we", 32'(dev_we), 32'h0);
    check("wr_t2_ack", 32'(m0_ack), 32'h1);
    check("wr_t2_err", 32'(m0_err), 32'h0);
    check("wr_t2_m1_ack", 32'(m1_ack), 32'h0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    check("wr_t3_ack", 32'(m0_ack), 32'h0);
    check("wr_reg", regs[0][0], 32'h9);

    // m0 preloads slot 1 reg 1, then m1 reads it back
    run_access(0, 1'b1, 32'h0000_7F14, 32'h0000_1234, lat, err, rd, wes, add, oack);
    check("pre_lat", 32'(lat), 32'd2);
    check("pre_we", 32'(wes), 32'h2);
    run_access(1, 1'b0, 32'h0000_7F14, 32'h0, lat, err, rd, wes, add, oack);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_add", 32'(add), 32'h4);
    check("rd_data", rd, 32'h0000_1234);
    check("rd_err", 32'(err), 32'h0);
    check("rd_m0_ack", 32'(oack), 32'h0);
    check("rd_no_we", 32'(wes), 32'h0);

    // Contention twice: m0 first each time, acks at +2 and +5
    contend(1'b1, 32'h0000_7F04, 32'h0000_000A, 32'h0000_7F18, 32'h0000_000B,
            t0, t1, r0, r1, mwe);
    check("c1_m0_ack_cyc", 32'(t0), 32'd2);
    check("c1_m1_ack_cyc", 32'(t1), 32'd5);
    check("c1_one_hot", 32'(mwe), 32'h0);
    check("c1_reg0", regs[0][1], 32'hA);
    check("c1_reg1", regs[1][2], 32'hB);
    contend(1'b0, 32'h0000_7F04, 32'h0, 32'h0000_7F18, 32'h0, t0, t1, r0, r1, mwe);
    check("c2_m0_ack_cyc", 32'(t0), 32'd2);
    check("c2_m1_ack_cyc", 32'(t1), 32'd5);
    check("c2_m0_rdata", r0, 32'hA);
    check("c2_m1_rdata", r1, 32'hB);

    // Unmapped, misaligned, and the no-register offset
    run_access(0, 1'b0, 32'h0000_7F20, 32'h0, lat, err, rd, wes, add, oack);
    check("unmap_lat", 32'(lat), 32'd2);
    check("unmap_err", 32'(err), 32'h1);
    check("unmap_rdata", rd, 32'h0);
    check("unmap_we", 32'(wes), 32'h0);
    run_access(1, 1'b1, 32'h0000_7F02, 32'h0000_5555, lat, err, rd, wes, add, oack);
    check("misal_err", 32'(err), 32'h1);
    check("misal_we", 32'(wes), 32'h0);
    check("misal_rdata", rd, 32'h0);
    run_access(0, 1'b1, 32'h0000_7F0C, 32'h0000_FFFF, lat, err, rd, wes, add, oack);
    check("offc_wr_err", 32'(err), 32'h0);
    check("offc_wr_we", 32'(wes), 32'h0);
    check("offc_wr_rdata", rd, 32'h0);
    run_access(1, 1'b0, 32'h0000_7F1C, 32'h0, lat, err, rd, wes, add, oack);
    check("offc_rd_err", 32'(err), 32'h0);
    check("offc_rd_rdata", rd, 32'h0);
    run_access(0, 1'b0, 32'h0000_7EFC, 32'h0, lat, err, rd, wes, add, oack);
    check("below_base_err", 32'(err), 32'h1);

    // Reset during ACCESS of a write
    drive(0, 1'b1, 1'b1, 32'h0000_7F08, 32'h0000_0055);
    step();
    reset = 1'b1;
    #1;
    check("rstacc_dev_we", 32'(dev_we), 32'h0);
    step();
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("rstacc_ack", 32'(m0_ack), 32'h0);
    check("rstacc_state", 32'(dut.state_q), 32'd0);
    step();
    check("rstacc_ack2", 32'(m0_ack), 32'h0);
    check("rstacc_reg", regs[0][2], 32'h0);
    run_access(0, 1'b1, 32'h0000_7F08, 32'h0000_0066, lat, err, rd, wes, add, oack);
    check("rstacc_retry_lat", 32'(lat), 32'd2);
    check("rstacc_retry_err", 32'(err), 32'h0);
    check("rstacc_retry_reg", regs[0][2], 32'h66);

    // Interrupt vector lags by one cycle
    dev_irq = 2'b10;
    #1;
    check("irq_t0", 32'(hwint), 32'h0);
    step();
    check("irq_t1", 32'(hwint), 32'h2);
    dev_irq = 2'b00;
    step();
    check("irq_clr", 32'(hwint), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
